// File: rtl/monster_hit_controller.sv
// Purpose : hit/explosion/death life cycle for NUM_MONSTERS monsters plus a
//           fixed-priority arbiter that serialises kills into a score stream.
// Latency : collision at edge k -> monsterIsHit after edge k, scorePulse after k+1.
// Backpressure: none; pending kills queue in a bit vector, one granted per cycle.
//
// Ports:
//   clk, resetN            clock, asynchronous active-low reset
//   startOfFrame           one-cycle pulse per video frame (advances explosions)
//   levelRestart           synchronous clear, all monsters back to ALIVE
//   collision[i]           shot hit monster i this cycle
//   monsterIsHit[i]        monster i shows the explosion bitmap
//   monsterVisible[i]      monster i's drawing request is allowed
//   scorePulse/scoreIndex  one pulse per kill with the killed monster's index
//   allDead                every monster is DEAD
//
// Optional feature macro: MONSTER_BLINK_EN -- the last BLINK_FRAMES explosion
// frames blink (visibility follows the inverted frame counter LSB).
module monster_hit_controller #(
    parameter int NUM_MONSTERS     = 8,
    parameter int EXPLOSION_FRAMES = 16,
    parameter int BLINK_FRAMES     = 6
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    startOfFrame,
    input  logic                    levelRestart,
    input  logic [NUM_MONSTERS-1:0] collision,
    output logic [NUM_MONSTERS-1:0] monsterIsHit,
    output logic [NUM_MONSTERS-1:0] monsterVisible,
    output logic                    scorePulse,
    output logic [((NUM_MONSTERS > 1) ? $clog2(NUM_MONSTERS) : 1)-1:0] scoreIndex,
    output logic                    allDead
);

    localparam int IDX_W = (NUM_MONSTERS > 1) ? $clog2(NUM_MONSTERS) : 1;
    localparam int CNT_W = $clog2(EXPLOSION_FRAMES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(EXPLOSION_FRAMES - 1);
    localparam logic [CNT_W-1:0] BLINK_START = CNT_W'(EXPLOSION_FRAMES - BLINK_FRAMES);
`ifdef MONSTER_BLINK_EN
    localparam bit BLINK_EN = 1'b1;
`else
    localparam bit BLINK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_ALIVE     = 2'd0,
        ST_EXPLODING = 2'd1,
        ST_DEAD      = 2'd2
    } state_e;

    state_e            state_q [NUM_MONSTERS];
    state_e            state_d [NUM_MONSTERS];
    logic [CNT_W-1:0]  cnt_q   [NUM_MONSTERS];
    logic [CNT_W-1:0]  cnt_d   [NUM_MONSTERS];

    logic [NUM_MONSTERS-1:0] pending_q, pending_d;
    logic [NUM_MONSTERS-1:0] new_kill;
    logic [NUM_MONSTERS-1:0] grant_mask;
    logic [NUM_MONSTERS-1:0] dead_vec;
    logic [IDX_W-1:0]        grant_idx;
    logic                    any_pending;

    logic                    score_pulse_q, score_pulse_d;
    logic [IDX_W-1:0]        score_idx_q, score_idx_d;
    logic                    all_dead_q, all_dead_d;

    // State register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_MONSTERS; i++) begin
                state_q[i] <= ST_ALIVE;
                cnt_q[i]   <= '0;
            end
            pending_q     <= '0;
            score_pulse_q <= 1'b0;
            score_idx_q   <= '0;
            all_dead_q    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_MONSTERS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            pending_q     <= pending_d;
            score_pulse_q <= score_pulse_d;
            score_idx_q   <= score_idx_d;
            all_dead_q    <= all_dead_d;
        end
    end

    // Next-state logic: per-monster FSMs. A startOfFrame on the entering edge
    // is not counted because the monster is still ALIVE at that edge.
    always_comb begin
        new_kill = '0;
        for (int i = 0; i < NUM_MONSTERS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (levelRestart) begin
                state_d[i] = ST_ALIVE;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    ST_ALIVE: begin
                        if (collision[i]) begin
                            state_d[i]  = ST_EXPLODING;
                            cnt_d[i]    = '0;
                            new_kill[i] = 1'b1;
                        end
                    end
                    ST_EXPLODING: begin
                        if (startOfFrame) begin
                            if (cnt_q[i] == LAST_CNT) begin
                                state_d[i] = ST_DEAD;
                            end else begin
                                cnt_d[i] = cnt_q[i] + 1'b1;
                            end
                        end
                    end
                    ST_DEAD: begin
                        state_d[i] = ST_DEAD;
                    end
                    default: begin
                        state_d[i] = ST_ALIVE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    // Score arbiter: lowest pending index wins. Kills registered this edge are
    // OR-ed in after the grant is removed, so they are never lost.
    always_comb begin
        any_pending = |pending_q;
        grant_idx   = '0;
        for (int i = NUM_MONSTERS - 1; i >= 0; i--) begin
            if (pending_q[i]) grant_idx = IDX_W'(i);
        end
        // Isolate the lowest set bit.
        grant_mask = pending_q & (~pending_q + 1'b1);

        for (int i = 0; i < NUM_MONSTERS; i++) begin
            dead_vec[i] = (state_q[i] == ST_DEAD);
        end

        if (levelRestart) begin
            pending_d     = '0;
            score_pulse_d = 1'b0;
            score_idx_d   = score_idx_q;
            all_dead_d    = 1'b0;
        end else begin
            pending_d     = (pending_q & ~grant_mask) | new_kill;
            score_pulse_d = any_pending;
            score_idx_d   = any_pending ? grant_idx : score_idx_q;
            all_dead_d    = &dead_vec;
        end
    end

    // Output decode, purely from registered state.
    always_comb begin
        for (int i = 0; i < NUM_MONSTERS; i++) begin
            monsterIsHit[i]   = (state_q[i] == ST_EXPLODING);
            monsterVisible[i] = (state_q[i] != ST_DEAD);
            if (BLINK_EN && (state_q[i] == ST_EXPLODING) && (cnt_q[i] >= BLINK_START)) begin
                monsterVisible[i] = ~cnt_q[i][0];
            end
        end
        scorePulse = score_pulse_q;
        scoreIndex = score_idx_q;
        allDead    = all_dead_q;
    end

endmodule

// File: tb/tb_monster_hit_controller.sv
module tb_monster_hit_controller;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame;
    logic       levelRestart;
    logic [7:0] collision;
    logic [7:0] monsterIsHit;
    logic [7:0] monsterVisible;
    logic       scorePulse;
    logic [2:0] scoreIndex;
    logic       allDead;

    int n_cmp = 0;
    int n_err = 0;
    int pulse_q[$];

    always #5 clk = ~clk;

    monster_hit_controller #(
        .NUM_MONSTERS(8),
        .EXPLOSION_FRAMES(16),
        .BLINK_FRAMES(6)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .startOfFrame(startOfFrame),
        .levelRestart(levelRestart),
        .collision(collision),
        .monsterIsHit(monsterIsHit),
        .monsterVisible(monsterVisible),
        .scorePulse(scorePulse),
        .scoreIndex(scoreIndex),
        .allDead(allDead)
    );

    // Record every score pulse (sampled away from the active edge).
    always @(negedge clk) begin
        if (scorePulse === 1'b1) pulse_q.push_back(int'(scoreIndex));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One video frame: startOfFrame for one cycle, then two idle cycles.
    task automatic frame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        startOfFrame = 1'b0;
        levelRestart = 1'b0;
        collision = 8'h00;
        #12;
        n_cmp++;
        if ({monsterIsHit, monsterVisible, scorePulse, allDead} !== {8'h00, 8'hFF, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_outputs: got hit=%h vis=%h pulse=%b alldead=%b, want 00 ff 0 0",
                     monsterIsHit, monsterVisible, scorePulse, allDead);
        end
        n_cmp++;
        if (scoreIndex !== 3'd0) begin
            n_err++;
            $display("FAIL reset_index: got %0d want 0", scoreIndex);
        end
        @(negedge clk);
        resetN = 1'b1;
        pulse_q.delete();
        repeat (3) frame();
        n_cmp++;
        if ({monsterIsHit, monsterVisible, allDead} !== {8'h00, 8'hFF, 1'b0}) begin
            n_err++;
            $display("FAIL idle_outputs: got hit=%h vis=%h alldead=%b, want 00 ff 0",
                     monsterIsHit, monsterVisible, allDead);
        end
        n_cmp++;
        if (pulse_q.size() != 0) begin
            n_err++;
            $display("FAIL idle_no_pulse: got %0d pulses want 0", pulse_q.size());
        end
    endtask

    task automatic test_single_kill();
        pulse_q.delete();
        collision = 8'h04;
        tick();
        collision = 8'h00;
        n_cmp++;
        if (monsterIsHit !== 8'h04 || scorePulse !== 1'b0) begin
            n_err++;
            $display("FAIL single_hit: got hit=%h pulse=%b want 04 0", monsterIsHit, scorePulse);
        end
        tick();
        n_cmp++;
        if (scorePulse !== 1'b1 || scoreIndex !== 3'd2) begin
            n_err++;
            $display("FAIL single_pulse: got pulse=%b idx=%0d want 1 2", scorePulse, scoreIndex);
        end
        tick();
        n_cmp++;
        if (scorePulse !== 1'b0) begin
            n_err++;
            $display("FAIL single_pulse_width: got pulse=%b want 0", scorePulse);
        end
        repeat (15) frame();
        n_cmp++;
        if (monsterIsHit !== 8'h04) begin
            n_err++;
            $display("FAIL single_15_frames: got hit=%h want 04", monsterIsHit);
        end
        frame();
        n_cmp++;
        if (monsterIsHit !== 8'h00 || monsterVisible !== 8'hFB) begin
            n_err++;
            $display("FAIL single_dead: got hit=%h vis=%h want 00 fb", monsterIsHit, monsterVisible);
        end
        n_cmp++;
        if (pulse_q.size() != 1) begin
            n_err++;
            $display("FAIL single_pulse_count: got %0d want 1", pulse_q.size());
        end
    endtask

    task automatic test_simultaneous();
        int exp_idx[3] = '{0, 5, 7};
        pulse_q.delete();
        collision = 8'hA1;
        tick();
        collision = 8'h00;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (scorePulse !== 1'b1 || int'(scoreIndex) != exp_idx[k]) begin
                n_err++;
                $display("FAIL multi_pulse%0d: got pulse=%b idx=%0d want 1 %0d",
                         k, scorePulse, scoreIndex, exp_idx[k]);
            end
        end
        tick();
        n_cmp++;
        if (scorePulse !== 1'b0) begin
            n_err++;
            $display("FAIL multi_end: got pulse=%b want 0", scorePulse);
        end
        // Re-hit during explosion must not re-trigger.
        collision = 8'hA1;
        tick();
        collision = 8'h00;
        repeat (4) tick();
        n_cmp++;
        if (pulse_q.size() != 3 || monsterIsHit !== 8'hA1) begin
            n_err++;
            $display("FAIL multi_retrigger: got pulses=%0d hit=%h want 3 a1", pulse_q.size(), monsterIsHit);
        end
        repeat (16) frame();
        n_cmp++;
        if (monsterVisible !== 8'h5A || monsterIsHit !== 8'h00 || allDead !== 1'b0) begin
            n_err++;
            $display("FAIL multi_dead: got vis=%h hit=%h alldead=%b want 5a 00 0",
                     monsterVisible, monsterIsHit, allDead);
        end
    endtask

    task automatic test_all_dead();
        pulse_q.delete();
        collision = 8'h0A;
        tick();
        collision = 8'h00;
        frame();
        collision = 8'h10;
        tick();
        collision = 8'h00;
        repeat (2) frame();
        collision = 8'h40;
        tick();
        collision = 8'h00;
        repeat (15) frame();
        n_cmp++;
        if (monsterIsHit !== 8'h40 || allDead !== 1'b0) begin
            n_err++;
            $display("FAIL alldead_before: got hit=%h alldead=%b want 40 0", monsterIsHit, allDead);
        end
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        n_cmp++;
        if (monsterVisible !== 8'h00 || allDead !== 1'b0) begin
            n_err++;
            $display("FAIL alldead_last_edge: got vis=%h alldead=%b want 00 0", monsterVisible, allDead);
        end
        tick();
        n_cmp++;
        if (allDead !== 1'b1) begin
            n_err++;
            $display("FAIL alldead_set: got %b want 1", allDead);
        end
        n_cmp++;
        if (pulse_q.size() != 4 || pulse_q[0] != 1 || pulse_q[1] != 3 || pulse_q[2] != 4 || pulse_q[3] != 6) begin
            n_err++;
            $display("FAIL alldead_pulses: got count=%0d, want 4 pulses idx 1 3 4 6", pulse_q.size());
        end
        levelRestart = 1'b1;
        tick();
        levelRestart = 1'b0;
        n_cmp++;
        if (monsterVisible !== 8'hFF || allDead !== 1'b0 || monsterIsHit !== 8'h00) begin
            n_err++;
            $display("FAIL restart_clear: got vis=%h alldead=%b hit=%h want ff 0 00",
                     monsterVisible, allDead, monsterIsHit);
        end
    endtask

    task automatic test_restart_discard();
        pulse_q.delete();
        collision = 8'h03;
        tick();
        collision = 8'h00;
        levelRestart = 1'b1;
        tick();
        levelRestart = 1'b0;
        n_cmp++;
        if (scorePulse !== 1'b0 || monsterIsHit !== 8'h00 || monsterVisible !== 8'hFF) begin
            n_err++;
            $display("FAIL restart_discard: got pulse=%b hit=%h vis=%h want 0 00 ff",
                     scorePulse, monsterIsHit, monsterVisible);
        end
        repeat (3) tick();
        n_cmp++;
        if (pulse_q.size() > 1 || (pulse_q.size() == 1 && pulse_q[0] != 0)) begin
            n_err++;
            $display("FAIL restart_pulses: got %0d pulses, want at most one with index 0", pulse_q.size());
        end
        // levelRestart overrides a coincident collision.
        collision = 8'h10;
        levelRestart = 1'b1;
        tick();
        collision = 8'h00;
        levelRestart = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if (monsterIsHit !== 8'h00 || pulse_q.size() > 1) begin
            n_err++;
            $display("FAIL restart_override: got hit=%h pulses=%0d want 00 <=1", monsterIsHit, pulse_q.size());
        end
    endtask

    task automatic test_reset_mid();
        collision = 8'h81;
        tick();
        collision = 8'h00;
        tick();
        #2;
        resetN = 1'b0;
        #1;
        n_cmp++;
        if ({monsterIsHit, monsterVisible, scorePulse, allDead} !== {8'h00, 8'hFF, 1'b0, 1'b0}
            || scoreIndex !== 3'd0) begin
            n_err++;
            $display("FAIL reset_mid: got hit=%h vis=%h pulse=%b idx=%0d alldead=%b want 00 ff 0 0 0",
                     monsterIsHit, monsterVisible, scorePulse, scoreIndex, allDead);
        end
        pulse_q.delete();
        repeat (2) tick();
        resetN = 1'b1;
        repeat (4) tick();
        n_cmp++;
        if (pulse_q.size() != 0 || monsterIsHit !== 8'h00) begin
            n_err++;
            $display("FAIL reset_mid_after: got pulses=%0d hit=%h want 0 00", pulse_q.size(), monsterIsHit);
        end
    endtask

`ifdef MONSTER_BLINK_EN
    task automatic test_blink();
        logic exp_vis;
        collision = 8'h01;
        tick();
        collision = 8'h00;
        for (int n = 0; n <= 16; n++) begin
            if (n < 10)      exp_vis = 1'b1;
            else if (n < 16) exp_vis = (n % 2 == 0);
            else             exp_vis = 1'b0;
            n_cmp++;
            if (monsterVisible[0] !== exp_vis) begin
                n_err++;
                $display("FAIL blink_frame%0d: got vis0=%b want %b", n, monsterVisible[0], exp_vis);
            end
            frame();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_kill();
        test_simultaneous();
        test_all_dead();
        test_restart_discard();
        test_reset_mid();
`ifdef MONSTER_BLINK_EN
        test_blink();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
